// File: rtl/bus_mux_rr_if.sv
// Handshake bundle for bus_mux_rr: N producer channels in, one consumer channel out.
// XFER_CNT is present only when BUS_MUX_STATS_EN is defined.
interface bus_mux_rr_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 8,
  parameter int SEL_WIDTH  = 3
);
  logic [CHANNELS*DATA_WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]            in_valid;
  logic [CHANNELS-1:0]            in_ready;
  logic                           mode;
  logic [SEL_WIDTH-1:0]           sel;
  logic [DATA_WIDTH-1:0]          out_data;
  logic                           out_valid;
  logic                           out_ready;
  logic [SEL_WIDTH-1:0]           out_ch;
`ifdef BUS_MUX_STATS_EN
  logic [15:0]                    xfer_cnt;

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_valid, out_ch, xfer_cnt
  );
  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_valid, out_ch, xfer_cnt
  );
`else
  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_valid, out_ch
  );
  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_valid, out_ch
  );
`endif
endinterface

// File: rtl/bus_mux_rr.sv
// Registered N:1 bus selector with valid/ready handshake; direct (SEL) or round-robin grant.
// Optional transfer counter XFER_CNT enabled by defining BUS_MUX_STATS_EN.
module bus_mux_rr #(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 8,
  parameter int SEL_WIDTH  = 3
) (
  input logic         clk,
  input logic         rst,
  bus_mux_rr_if.slave bus
);
  localparam logic [SEL_WIDTH-1:0] LAST_INIT = SEL_WIDTH'(CHANNELS - 1);

  logic [DATA_WIDTH-1:0] out_data_r;
  logic                  out_valid_r;
  logic [SEL_WIDTH-1:0]  out_ch_r;
  logic [SEL_WIDTH-1:0]  last_r;

  logic                  slot_s;
  logic                  rr_hit_s;
  logic                  rr_take_s;
  int                    rr_idx_s;
  logic [SEL_WIDTH-1:0]  rr_grant_s;
  logic                  grant_ok_s;
  logic [SEL_WIDTH-1:0]  grant_s;
  logic [CHANNELS-1:0]   ready_s;
  logic                  xfer_s;
  logic [DATA_WIDTH-1:0] sel_data_s;

  // round-robin search: first valid channel after the last winner, wrapping
  always_comb begin
    rr_hit_s   = 1'b0;
    rr_take_s  = 1'b0;
    rr_idx_s   = 0;
    rr_grant_s = '0;
    for (int i = 1; i <= CHANNELS; i++) begin
      rr_idx_s   = (int'(last_r) + i) % CHANNELS;
      rr_take_s  = !rr_hit_s && bus.in_valid[rr_idx_s];
      rr_grant_s = rr_take_s ? SEL_WIDTH'(rr_idx_s) : rr_grant_s;
      rr_hit_s   = rr_hit_s | rr_take_s;
    end
  end

  // grant selection by mode; out-of-range SEL yields no grant
  always_comb begin
    grant_ok_s = 1'b0;
    grant_s    = '0;
    case (bus.mode)
      1'b0: begin
        grant_s    = bus.sel;
        grant_ok_s = (int'(bus.sel) < CHANNELS);
      end
      1'b1: begin
        grant_s    = rr_grant_s;
        grant_ok_s = rr_hit_s;
      end
      default: begin
        grant_s    = '0;
        grant_ok_s = 1'b0;
      end
    endcase
  end

  // accept strobes and the granted channel's data word
  always_comb begin
    slot_s     = !out_valid_r || bus.out_ready;
    ready_s    = '0;
    sel_data_s = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      ready_s[k] = !rst && slot_s && grant_ok_s && (int'(grant_s) == k) && bus.in_valid[k];
      sel_data_s = (int'(grant_s) == k) ? bus.in_data[k*DATA_WIDTH +: DATA_WIDTH] : sel_data_s;
    end
    xfer_s = |ready_s;
  end

  // output register stage and round-robin pointer; drain and load may coincide
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      out_ch_r    <= '0;
      last_r      <= LAST_INIT;
    end else if (xfer_s) begin
      out_data_r  <= sel_data_s;
      out_ch_r    <= grant_s;
      out_valid_r <= 1'b1;
      last_r      <= bus.mode ? grant_s : last_r;
    end else if (out_valid_r && bus.out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign bus.in_ready  = ready_s;
  assign bus.out_data  = out_data_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_ch    = out_ch_r;

`ifdef BUS_MUX_STATS_EN
  logic [15:0] xfer_cnt_r;

  // saturating count of accepted input words
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_cnt_r <= 16'h0000;
    end else if (xfer_s && (xfer_cnt_r != 16'hFFFF)) begin
      xfer_cnt_r <= xfer_cnt_r + 16'h0001;
    end else begin
      xfer_cnt_r <= xfer_cnt_r;
    end
  end

  assign bus.xfer_cnt = xfer_cnt_r;
`else
`endif
endmodule

// File: doc/bus_mux_rr.md
Name: bus_mux_rr

Overview:
- Registered, parametrised N-to-1 bus selector for the microprocessor datapath.
- Generalises the combinational 8:1 mux in three ways: channel count and width are parameters; each input and the output carry a valid/ready handshake; a second selection mode arbitrates round-robin among requesting channels.
- Sits between multiple data producers (ALU, register file, memory read port, I/O) and a single consumer bus.
- One output register stage; latency is 1 cycle.

Parameters:
- DATA_WIDTH, 8, width of each data channel in bits.
- CHANNELS, 8, number of input channels; legal range 2..16.
- SEL_WIDTH, 3, width of SEL and OUT_CH; must satisfy 2**SEL_WIDTH >= CHANNELS.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- IN  input  CHANNELS*DATA_WIDTH  packed input data; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- IN_VALID  input  CHANNELS  per-channel data-valid.
- IN_READY  output  CHANNELS  per-channel accept strobe; combinational; at most one bit high.
- MODE  input  1  0 = direct select by SEL; 1 = round-robin arbitration.
- SEL  input  SEL_WIDTH  channel select; used only when MODE=0.
- OUT  output  DATA_WIDTH  registered output data.
- OUT_VALID  output  1  OUT holds a word not yet accepted.
- OUT_READY  input  1  consumer accepts OUT this cycle.
- OUT_CH  output  SEL_WIDTH  channel index that produced OUT.

Behaviour:
- Reset (asynchronous, takes effect mid-operation): OUT=0, OUT_VALID=0, OUT_CH=0, round-robin pointer LAST=CHANNELS-1. A word in flight is discarded. IN_READY is 0 while RST is high.
- Slot free: SLOT = !OUT_VALID || OUT_READY.
- Grant: one channel G per cycle, chosen combinationally; IN_READY[G] = SLOT && IN_VALID[G]; all other IN_READY bits are 0.
- MODE=0 (direct):
  - G = SEL.
  - If SEL >= CHANNELS, there is no grant and all IN_READY bits are 0.
  - The LAST pointer is held.
- MODE=1 (round-robin):
  - Search LAST+1, LAST+2, ... wrapping at CHANNELS-1 -> 0.
  - G is the first channel with IN_VALID set; if none is set, there is no grant.
  - On a transfer, LAST <= G.
  - SEL is ignored.
- Transfer: on a rising edge with IN_READY[G]=1, OUT <= IN[G], OUT_CH <= G, OUT_VALID <= 1.
- Drain: on a rising edge with OUT_VALID && OUT_READY and no new transfer, OUT_VALID <= 0. OUT and OUT_CH hold their last values.
- Simultaneous drain and load: allowed in the same cycle, giving back-to-back throughput of 1 word per cycle.
- Backpressure: while OUT_VALID=1 and OUT_READY=0, OUT, OUT_CH and OUT_VALID are stable and all IN_READY bits are 0.
- MODE change: sampled combinationally, so it affects the grant in the same cycle. It never corrupts a registered word.
- Round-robin fairness: with all channels requesting continuously, the grant order is 0, 1, ..., CHANNELS-1, 0, ...

Optional Feature:
- Macro: BUS_MUX_STATS_EN.
- Defined:
  - Adds output port XFER_CNT (16 bits), a count of completed input transfers.
  - Increments on every cycle in which any IN_READY bit and its matching IN_VALID bit are both 1.
  - Saturates at 16'hFFFF.
  - Cleared to 0 by RST.
- Undefined: the XFER_CNT port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset: assert RST mid-transfer with OUT_VALID=1 -> OUT=0, OUT_VALID=0, OUT_CH=0 immediately, without waiting for a clock edge; after release, MODE=1 with all channels valid grants channel 0 first.
- Direct mode: MODE=0, SEL=5, IN ch5=8'hA5, IN_VALID=8'hFF, OUT_READY=1 -> IN_READY=8'h20; next cycle OUT=8'hA5, OUT_CH=5, OUT_VALID=1.
- Invalid select: CHANNELS=6, MODE=0, SEL=7, all IN_VALID high -> IN_READY=0 and OUT_VALID stays 0.
- Round-robin: MODE=1, IN_VALID=8'b1000_0101, OUT_READY=1 -> grants 0, 2, 7, 0 on consecutive cycles, each visible as OUT_CH one cycle later.
- Backpressure: OUT_VALID=1, OUT_READY=0 for 4 cycles with input data changing -> OUT and OUT_CH unchanged, IN_READY=0; raise OUT_READY -> a new word loads in that same cycle.
- Stats (with BUS_MUX_STATS_EN): 10 transfers -> XFER_CNT=10; force 70000 transfers -> XFER_CNT=16'hFFFF.
